// File: rtl/float_to_int.sv
// float_to_int: multi-cycle IEEE-754 single-precision to int32 converter, shifting one bit per cycle.
// Define FTOI_ROUND_NEAREST_EN for round-to-nearest-even; by default the result is truncated toward zero.
module float_to_int (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        Overflow,
    output logic        Underflow,
    output logic        Exception
);
    typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;
    state_t      r_state, w_state_nx;
    logic [31:0] r_w;
    logic [7:0]  r_n;
    logic        r_left, r_sign;
`ifdef FTOI_ROUND_NEAREST_EN
    logic        r_g, r_s;
`endif
    logic        w_sign, w_accept, w_inf_nan, w_zero, w_ovf, w_special;
    logic [7:0]  w_exp, w_n;
    logic [22:0] w_man;
    logic [31:0] w_spec_data, w_mag, w_res;
    assign w_sign    = in_data[31];
    assign w_exp     = in_data[30:23];
    assign w_man     = in_data[22:0];
    assign in_ready  = r_state == IDLE;
    assign out_valid = r_state == DONE;
    assign w_accept  = in_valid & in_ready;
    assign w_inf_nan = w_exp == 8'hFF;
    assign w_zero    = w_exp == 8'h00;
    // -2^31 is exactly representable, so it takes the normal path instead of saturating
    assign w_ovf     = ~w_inf_nan & (w_exp >= 8'd158) & ~(w_sign & w_exp == 8'd158 & w_man == 23'd0);
    assign w_special = w_inf_nan | w_zero | w_ovf;
    assign w_n       = (w_exp >= 8'd150) ? w_exp - 8'd150 : (w_exp < 8'd125) ? 8'd25 : 8'd150 - w_exp;
    assign w_spec_data = w_zero ? 32'd0 :
                         (w_sign & ~(w_inf_nan & w_man != 23'd0)) ? 32'h8000_0000 : 32'h7FFF_FFFF;
`ifdef FTOI_ROUND_NEAREST_EN
    assign w_mag = r_w + {31'd0, r_g & (r_s | r_w[0])};
`else
    assign w_mag = r_w;
`endif
    assign w_res = r_sign ? -w_mag : w_mag;
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nx = w_special ? DONE : (w_n == 8'd0) ? ROUND : SHIFT;
            SHIFT:   if (r_n == 8'd1) w_state_nx = ROUND;
            ROUND:   w_state_nx = DONE;
            DONE:    if (out_ready) w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nx;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_w       <= 32'd0;
            r_n       <= 8'd0;
            r_left    <= 1'b0;
            r_sign    <= 1'b0;
            out_data  <= 32'd0;
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
            Exception <= 1'b0;
`ifdef FTOI_ROUND_NEAREST_EN
            r_g       <= 1'b0;
            r_s       <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    r_w       <= {8'd0, 1'b1, w_man};
                    r_n       <= w_n;
                    r_left    <= w_exp >= 8'd150;
                    r_sign    <= w_sign;
                    out_data  <= w_special ? w_spec_data : 32'd0;
                    Overflow  <= w_ovf;
                    Underflow <= w_zero & (w_man != 23'd0);
                    Exception <= w_inf_nan;
`ifdef FTOI_ROUND_NEAREST_EN
                    r_g       <= 1'b0;
                    r_s       <= 1'b0;
`endif
                end
                SHIFT: begin
                    r_w <= r_left ? r_w << 1 : r_w >> 1;
                    r_n <= r_n - 8'd1;
`ifdef FTOI_ROUND_NEAREST_EN
                    if (!r_left) begin
                        r_g <= r_w[0];
                        r_s <= r_s | r_g;
                    end
`endif
                end
                ROUND: begin
                    out_data  <= w_res;
                    Overflow  <= 1'b0;
                    Underflow <= w_mag == 32'd0;
                    Exception <= 1'b0;
                end
                DONE: if (out_ready) begin
                    out_data  <= 32'd0;
                    Overflow  <= 1'b0;
                    Underflow <= 1'b0;
                    Exception <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_float_to_int.sv
// tb_float_to_int: directed vectors for float_to_int; expectations follow FTOI_ROUND_NEAREST_EN.
module tb_float_to_int;
`ifdef FTOI_ROUND_NEAREST_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif
    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] in_data = 32'd0;
    logic        in_ready, out_valid, Overflow, Underflow, Exception;
    logic [31:0] out_data;
    int n_tests = 0, n_fail = 0;

    typedef struct {
        logic [31:0] din;
        logic [31:0] dout;
        logic        ovf;
        logic        unf;
        logic        exc;
        int          lat;
    } vec_t;
    vec_t v[$];

    float_to_int dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .Overflow(Overflow), .Underflow(Underflow), .Exception(Exception)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Presents one operand, returns edges from accept (inclusive) until out_valid is seen.
    task automatic run(input logic [31:0] d, output int lat);
        @(negedge clk);
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        logic [31:0] held;
        logic [2:0]  held_f;
        v.push_back('{32'h3F800000, 32'h00000001, 1'b0, 1'b0, 1'b0, 25});
        v.push_back('{32'h40200000, 32'h00000002, 1'b0, 1'b0, 1'b0, 24});
        v.push_back('{32'h40600000, RNE ? 32'h00000004 : 32'h00000003, 1'b0, 1'b0, 1'b0, 24});
        v.push_back('{32'hBFC00000, RNE ? 32'hFFFFFFFE : 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 25});
        v.push_back('{32'h4F000000, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 1});
        v.push_back('{32'hCF000000, 32'h80000000, 1'b0, 1'b0, 1'b0, 10});
        v.push_back('{32'h4EFFFFFF, 32'h7FFFFF80, 1'b0, 1'b0, 1'b0, 9});
        v.push_back('{32'h7FC00000, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 1});
        v.push_back('{32'hFF800000, 32'h80000000, 1'b0, 1'b0, 1'b1, 1});
        v.push_back('{32'h7F800000, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 1});
        v.push_back('{32'hFFC00000, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 1});
        v.push_back('{32'h3E800000, 32'h00000000, 1'b0, 1'b1, 1'b0, 27});
        v.push_back('{32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0, 1});
        v.push_back('{32'h00000001, 32'h00000000, 1'b0, 1'b1, 1'b0, 1});
        v.push_back('{32'h47000000, 32'h00008000, 1'b0, 1'b0, 1'b0, 10});
        v.push_back('{32'h4B000000, 32'h00800000, 1'b0, 1'b0, 1'b0, 2});
        v.push_back('{32'hC2F60000, 32'hFFFFFF85, 1'b0, 1'b0, 1'b0, 19});
        v.push_back('{32'h3F000000, 32'h00000000, 1'b0, 1'b1, 1'b0, 26});
        v.push_back('{32'h3F400000, RNE ? 32'h00000001 : 32'h00000000, 1'b0, !RNE, 1'b0, 26});
        v.push_back('{32'hCF000001, 32'h80000000, 1'b1, 1'b0, 1'b0, 1});
        v.push_back('{32'h4F800000, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 1});

        #12;
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset out_data", out_data, 32'd0);
        chk("reset flags", {29'd0, Overflow, Underflow, Exception}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < v.size(); i++) begin
            run(v[i].din, lat);
            chk($sformatf("v%0d %h latency", i, v[i].din), lat, v[i].lat);
            chk($sformatf("v%0d %h data", i, v[i].din), out_data, v[i].dout);
            chk($sformatf("v%0d %h flags(ovf,unf,exc)", i, v[i].din),
                {29'd0, Overflow, Underflow, Exception}, {29'd0, v[i].ovf, v[i].unf, v[i].exc});
            release_result();
            chk($sformatf("v%0d return idle", i), {30'd0, in_ready, out_valid}, 32'd2);
        end

        run(32'h40600000, lat);
        held   = out_data;
        held_f = {Overflow, Underflow, Exception};
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("hold%0d valid/ready", k), {30'd0, out_valid, in_ready}, 32'd2);
            chk($sformatf("hold%0d data", k), out_data, held);
            chk($sformatf("hold%0d flags", k), {29'd0, Overflow, Underflow, Exception}, {29'd0, held_f});
        end
        chk("hold data value", held, RNE ? 32'd4 : 32'd3);
        release_result();
        chk("hold release idle", {30'd0, in_ready, out_valid}, 32'd2);
        chk("hold release flags", {29'd0, Overflow, Underflow, Exception}, 32'd0);

        @(negedge clk);
        in_data  = 32'h3F800000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid-reset in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        chk("after reset in_ready", {31'd0, in_ready}, 32'd1);
        lat = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) lat++;
        end
        chk("abandoned result valid cycles", lat, 0);
        run(32'hBFC00000, lat);
        chk("post-reset latency", lat, 25);
        chk("post-reset data", out_data, RNE ? 32'hFFFFFFFE : 32'hFFFFFFFF);
        release_result();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/float_to_int.md
FLOAT_TO_INT -- requirements
Module: float_to_int

Interface
REQ-001 The block SHALL have exactly one clock, and reset SHALL be asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 in_valid  input  1  in_data holds an operand.
REQ-005 in_ready  output  1  block can accept an operand; high only in IDLE.
REQ-006 in_data  input  32  IEEE-754 single-precision operand: sign[31], exp[30:23], mantissa[22:0].
REQ-007 out_valid  output  1  out_data and flags hold a result.
REQ-008 out_ready  input  1  consumer accepts the result.
REQ-009 out_data  output  32  two's-complement signed integer result.
REQ-010 Overflow  output  1  finite operand is outside the int32 range, so the result saturates.
REQ-011 Underflow  output  1  nonzero finite operand converts to 0.
REQ-012 Exception  output  1  operand exponent field is 255 (Inf or NaN).

Function
REQ-013 The FSM SHALL have four states: IDLE, SHIFT, ROUND and DONE.
REQ-014 An operand SHALL be accepted on a clock edge where in_valid and in_ready are both high.
REQ-015 On accept, the block SHALL load W = {1, mantissa} (24 bits) into the integer field of a working register that also holds guard and sticky bits.
REQ-016 Special operands SHALL go from IDLE to DONE in one edge, with no SHIFT or ROUND cycles:
- E = 255: Exception = 1; out_data = 0x80000000 for -Inf, otherwise 0x7FFFFFFF (NaN and +Inf).
- E = 0: out_data = 0; Underflow = 1 when the mantissa is nonzero (denormals are flushed).
- E >= 158: Overflow = 1; out_data = 0x80000000 if negative, else 0x7FFFFFFF.
- Exception: sign = 1, E = 158, mantissa = 0 is NOT overflow; it converts to 0x80000000 through the normal path.
REQ-017 Shift count N SHALL be fixed at accept:
- left by E - 150 when E >= 150 (N in 0..8);
- right by 150 - E when E < 150, with N capped at 25.
REQ-018 SHIFT SHALL move W one bit per cycle and decrement N; the state SHALL advance to ROUND when N reaches 0, and SHIFT SHALL be skipped when N = 0.
REQ-019 On a right shift, guard SHALL receive the bit shifted out, and sticky SHALL accumulate the OR of all earlier guard values.
REQ-020 ROUND SHALL apply the rounding rule of REQ-030, then negate the result if the sign is 1, register out_data and flags, and go to DONE.
REQ-021 Latency SHALL be N+2 edges from accept to out_valid for normal operands and 1 edge for special operands.
REQ-022 Rounding SHALL NOT overflow int32, because right shifts occur only when magnitude < 2^24.
REQ-023 DONE SHALL hold out_valid = 1 with out_data and flags stable until out_ready is high, then return to IDLE on that edge.
REQ-024 in_ready SHALL be low in SHIFT, ROUND and DONE.
REQ-025 in_data SHALL be ignored outside IDLE.
REQ-026 Underflow SHALL be set in ROUND when the operand is nonzero and the final magnitude is 0.
REQ-027 Flags SHALL be valid only while out_valid = 1, and SHALL be cleared on the return to IDLE.

Reset
REQ-028 While rst = 1 the block SHALL force:
- state = IDLE;
- out_valid = 0, out_data = 0, Overflow = 0, Underflow = 0, Exception = 0;
- W, N, guard and sticky = 0;
- in_ready = 1.
REQ-029 Reset asserted in SHIFT, ROUND or DONE SHALL abandon the operation; no result SHALL be emitted afterwards.

Configuration
REQ-030 Macro FTOI_ROUND_NEAREST_EN SHALL select the rounding rule:
- Defined: round to nearest even; the magnitude is incremented when guard & (sticky | LSB).
- Undefined: truncate toward zero; guard and sticky are discarded, and the guard/sticky logic may be removed.

Verification
REQ-031 1.0 (0x3F800000) -> out_data = 1 with all flags 0, and out_valid asserted exactly 25 edges after accept.
REQ-032 Rounding cases -> with FTOI_ROUND_NEAREST_EN defined / undefined:
- 2.5 (0x40200000) -> 2 / 2
- 3.5 (0x40600000) -> 4 / 3
- -1.5 (0xBFC00000) -> -2 (0xFFFFFFFE) / -1 (0xFFFFFFFF)
REQ-033 Range limits:
- 0x4F000000 -> 0x7FFFFFFF, Overflow = 1.
- 0xCF000000 -> 0x80000000, Overflow = 0.
- 0x4EFFFFFF -> 0x7FFFFF80, Overflow = 0.
REQ-034 Specials:
- 0x7FC00000 -> 0x7FFFFFFF, Exception = 1, out_valid 1 edge after accept.
- 0xFF800000 -> 0x80000000, Exception = 1.
- 0x3E800000 (0.25) -> 0, Underflow = 1.
- 0x00000000 -> 0, Underflow = 0.
REQ-035 Handshake: out_ready held low 5 cycles in DONE -> out_data and flags stable and in_ready = 0 throughout, and IDLE is entered on the edge where out_ready = 1.
REQ-036 Reset mid-operation: rst pulsed during SHIFT of operand 1.0 -> out_valid stays 0, in_ready = 1 after rst falls, and the next operand converts correctly.
